seg_scan_controller: RTL and testbench
======================================

SEG_SCAN_CONTROLLER -- requirements
Module: seg_scan_controller

Interface
REQ-001 Parameter SCAN_DIV, default 1000, SHALL set the clock cycles each digit stays selected (legal range 2..65535).
REQ-002 i_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 i_rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_count  input  14  SHALL carry the binary value to display, as produced by the count-up counter.
REQ-005 i_update  input  1  SHALL be a one-cycle request to capture i_count and refresh the display.
REQ-006 o_digit_sel  output  4  SHALL be a one-hot, active-high digit enable; bit 0 = ones, bit 3 = thousands.
REQ-007 o_seg  output  7  SHALL be active-high segments, bit order {g,f,e,d,c,b,a}.
REQ-008 o_busy  output  1  SHALL be high while a conversion is in progress.
REQ-009 o_ovf  output  1  SHALL be high while the displayed value came from a clamped capture (i_count > 9999).

Function
REQ-010 FSM SHALL have states IDLE, CONV and COMMIT; reset state is IDLE.
REQ-011 IDLE + i_update=1 SHALL capture min(i_count, 9999) and the overflow flag, then go to CONV; o_busy rises the next cycle.
REQ-012 CONV SHALL run exactly 14 cycles of iterative shift-and-add-3 binary-to-BCD (add 3 to any nibble >= 5 before each shift), one bit per cycle, MSB first.
REQ-013 COMMIT SHALL last 1 cycle, loading the four BCD digits and o_ovf into the display registers atomically, then return to IDLE.
REQ-014 o_busy SHALL be high for exactly 15 cycles per conversion (CONV + COMMIT).
REQ-015 Displayed digits SHALL change only at COMMIT; no partial conversion value is ever shown.
REQ-016 i_update during CONV/COMMIT SHALL set a single pending flag; further requests while pending merge into it.
REQ-017 With pending set, COMMIT SHALL go directly to CONV, capturing i_count in the COMMIT cycle, and clear the flag.
REQ-018 The scan counter SHALL count 0..SCAN_DIV-1 continuously, independent of the FSM; at SCAN_DIV-1 it wraps to 0 and the digit index advances 0->1->2->3->0.
REQ-019 o_digit_sel and o_seg SHALL be registered and update in the same cycle; o_seg always reflects the digit selected by o_digit_sel.
REQ-020 Digit values 0-9 SHALL decode to standard patterns (0 = 7'b0111111, 1 = 7'b0000110, 8 = 7'b1111111); undefined codes SHALL decode to 7'b0000000.
REQ-021 i_count = 9999 SHALL display 9999 with o_ovf=0; i_count >= 10000 SHALL display 9999 with o_ovf=1.

Reset
REQ-022 Asserting i_rst_n low SHALL immediately force: state IDLE, pending 0, scan counter 0, digit index 0, display digits 0000, o_digit_sel 4'b0001, o_seg 7'b0111111, o_busy 0, o_ovf 0.
REQ-023 Reset asserted mid-conversion SHALL discard the conversion; no COMMIT follows deassertion.
REQ-024 The first i_update SHALL be honoured in the cycle after i_rst_n deasserts.

Configuration
REQ-025 Macro SEG_SCAN_LEADING_ZERO_BLANK_EN defined: leading zero digits in thousands/hundreds/tens SHALL drive o_seg=7'b0000000; the ones digit is never blanked.
REQ-026 Macro undefined: all four digits SHALL always be shown, including leading zeros.
REQ-027 The macro SHALL NOT change timing, reset values of o_digit_sel/o_busy/o_ovf, or the FSM.

Verification
REQ-028 Reset, then i_update with i_count=1234 -> o_busy high 15 cycles; afterwards digits 3,2,1,0 show 1,2,3,4; o_ovf=0.
REQ-029 SCAN_DIV=4, free run -> o_digit_sel sequence 0001,0010,0100,1000, each held exactly 4 cycles, then repeats.
REQ-030 i_count=12000, i_update -> display 9999, o_ovf=1; then i_count=0, i_update -> 0000, o_ovf=0.
REQ-031 i_update with 5, then i_update with 42 and again with 43 during CONV -> display 5 after first COMMIT, exactly one more conversion, final display 43.
REQ-032 i_rst_n low at CONV cycle 7 of i_count=9876 -> all outputs at reset values, display stays 0000 after release.
REQ-033 SEG_SCAN_LEADING_ZERO_BLANK_EN defined, i_count=7 -> thousands/hundreds/tens o_seg=0, ones o_seg=7'b0000111; undefined -> 0007 shown.

Source files
------------

// File: rtl/seg_scan_if.sv
// seg_scan_if
//   Bundles the value/refresh request into the scan controller and the
//   multiplexed 7-segment outputs coming back from it.
//   master : drives i_count/i_update, observes the display outputs
//   slave  : the controller side
//   Signals:
//     i_count     [13:0] binary value to display
//     i_update           one-cycle capture/refresh request
//     o_digit_sel [3:0]  one-hot digit enable (bit 0 = ones)
//     o_seg       [6:0]  segments {g,f,e,d,c,b,a}, active high
//     o_busy             conversion in progress
//     o_ovf              displayed value was clamped to 9999
interface seg_scan_if;
   logic [13:0] i_count;
   logic        i_update;
   logic [3:0]  o_digit_sel;
   logic [6:0]  o_seg;
   logic        o_busy;
   logic        o_ovf;

   modport master (output i_count, i_update,
                   input  o_digit_sel, o_seg, o_busy, o_ovf);
   modport slave  (input  i_count, i_update,
                   output o_digit_sel, o_seg, o_busy, o_ovf);
endinterface

// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Captures a 14-bit count on request, clamps it to 9999, converts it to
//   four BCD digits with a 14-cycle shift-and-add-3 engine, then commits
//   the digits atomically to the display registers. A free-running scan
//   counter multiplexes the digits onto one 7-segment output.
//   Ports:
//     i_clk    clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      seg_scan_if.slave (i_count, i_update, o_digit_sel, o_seg,
//              o_busy, o_ovf)
//   Parameter:
//     SCAN_DIV clock cycles per digit (2..65535)
//   Build option:
//     SEG_SCAN_LEADING_ZERO_BLANK_EN  blank leading zeros in the upper
//     three digits (ones digit is always shown)
//
//   state  | meaning
//   IDLE   | waiting for i_update
//   CONV   | 14 shift-and-add-3 iterations, one input bit per cycle
//   COMMIT | load BCD result + overflow into display; restart if pending
module seg_scan_controller #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input logic       i_clk,
   input logic       i_rst_n,
   seg_scan_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

   state_t      r_state, w_state_nxt;
   logic [13:0] r_bin;
   logic [15:0] r_bcd;
   logic [3:0]  r_bit_cnt;
   logic        r_ovf_cap;
   logic        r_pend;
   logic [15:0] r_disp;
   logic        r_disp_ovf;
   logic [15:0] r_scan_cnt;
   logic [1:0]  r_dig_idx;
   logic [3:0]  r_digit_sel;
   logic [6:0]  r_seg;

   logic        w_capture, w_shift, w_commit;
   logic        w_over;
   logic [13:0] w_clamped;
   logic [15:0] w_bcd_adj;
   logic [15:0] w_disp_nxt;
   logic        w_disp_ovf_nxt;
   logic        w_scan_wrap;
   logic [1:0]  w_idx_nxt;
   logic [3:0]  w_dig_nxt;
   logic        w_blank;

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? n + 4'd3 : n;
   endfunction

   function automatic logic [6:0] seg_decode(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b0111111;
         4'd1:    return 7'b0000110;
         4'd2:    return 7'b1011011;
         4'd3:    return 7'b1001111;
         4'd4:    return 7'b1100110;
         4'd5:    return 7'b1101101;
         4'd6:    return 7'b1111101;
         4'd7:    return 7'b0000111;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_shift     = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.i_update) begin
               w_capture   = 1'b1;
               w_state_nxt = CONV;
            end
         end
         CONV: begin
            w_shift = 1'b1;
            if (r_bit_cnt == 4'd0) w_state_nxt = COMMIT;
         end
         COMMIT: begin
            w_commit = 1'b1;
            // A request landing in the commit cycle itself is merged into
            // the back-to-back restart rather than costing an IDLE cycle.
            if (r_pend || bus.i_update) begin
               w_capture   = 1'b1;
               w_state_nxt = CONV;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_over    = bus.i_count > 14'd9999;
   assign w_clamped = w_over ? 14'd9999 : bus.i_count;
   assign w_bcd_adj = {add3(r_bcd[15:12]), add3(r_bcd[11:8]),
                       add3(r_bcd[7:4]),   add3(r_bcd[3:0])};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_bin     <= '0;
         r_bcd     <= '0;
         r_bit_cnt <= '0;
         r_ovf_cap <= 1'b0;
         r_pend    <= 1'b0;
      end else begin
         if (w_capture) begin
            r_bin     <= w_clamped;
            r_bcd     <= '0;
            r_bit_cnt <= 4'd13;
            r_ovf_cap <= w_over;
         end else if (w_shift) begin
            r_bcd     <= {w_bcd_adj[14:0], r_bin[13]};
            r_bin     <= {r_bin[12:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - 4'd1;
         end
         if (w_capture)                              r_pend <= 1'b0;
         else if (bus.i_update && r_state != IDLE)   r_pend <= 1'b1;
      end
   end

   // Segment output is computed from next-cycle display/index so that
   // o_seg and o_digit_sel always change on the same edge.
   assign w_disp_nxt     = w_commit ? r_bcd : r_disp;
   assign w_disp_ovf_nxt = w_commit ? r_ovf_cap : r_disp_ovf;
   assign w_scan_wrap    = (r_scan_cnt == 16'(SCAN_DIV - 1));
   assign w_idx_nxt      = w_scan_wrap ? r_dig_idx + 2'd1 : r_dig_idx;
   assign w_dig_nxt      = w_disp_nxt[{w_idx_nxt, 2'b00} +: 4];

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
   always_comb begin
      w_blank = 1'b0;
      case (w_idx_nxt)
         2'd3:    w_blank = (w_disp_nxt[15:12] == 4'd0);
         2'd2:    w_blank = (w_disp_nxt[15:8]  == 8'd0);
         2'd1:    w_blank = (w_disp_nxt[15:4]  == 12'd0);
         default: w_blank = 1'b0;
      endcase
   end
`else
   assign w_blank = 1'b0;
`endif

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_disp      <= '0;
         r_disp_ovf  <= 1'b0;
         r_scan_cnt  <= '0;
         r_dig_idx   <= '0;
         r_digit_sel <= 4'b0001;
         r_seg       <= 7'b0111111;
      end else begin
         r_disp      <= w_disp_nxt;
         r_disp_ovf  <= w_disp_ovf_nxt;
         r_scan_cnt  <= w_scan_wrap ? 16'd0 : r_scan_cnt + 16'd1;
         r_dig_idx   <= w_idx_nxt;
         r_digit_sel <= 4'b0001 << w_idx_nxt;
         r_seg       <= w_blank ? 7'b0000000 : seg_decode(w_dig_nxt);
      end
   end

   assign bus.o_digit_sel = r_digit_sel;
   assign bus.o_seg       = r_seg;
   assign bus.o_busy      = (r_state != IDLE);
   assign bus.o_ovf       = r_disp_ovf;
endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seg_scan_if bus_a();
   seg_scan_if bus_b();

   seg_scan_controller #(.SCAN_DIV(2)) dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
   seg_scan_controller #(.SCAN_DIV(4)) dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

   int n_checks = 0;
   int n_errors = 0;
   int n_commits = 0;
   int n_exp_commits = 0;

   // expected display: {ovf, thousands, hundreds, tens, ones}
   logic [16:0] exp_q[$];
   logic        snap_req = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [6:0] seg_model(input logic [15:0] v, input int pos);
      logic [3:0] d;
      logic [6:0] tbl [10];
      tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
      d = v[pos*4 +: 4];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
      if (pos == 3 && v[15:12] == 0) return 7'h00;
      if (pos == 2 && v[15:8]  == 0) return 7'h00;
      if (pos == 1 && v[15:4]  == 0) return 7'h00;
`endif
      return (d < 10) ? tbl[d] : 7'h00;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   int         busy_run = 0;
   int         collect_left = 0;
   logic       prev_busy = 1'b0;
   logic [6:0] seen_seg [4];
   logic [3:0] seen_mask;
   logic       seen_ovf;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy_run     = 0;
         collect_left = 0;
         prev_busy    = 1'b0;
      end else begin
         if (collect_left > 0) begin
            int slot;
            slot = -1;
            case (bus_a.o_digit_sel)
               4'b0001: slot = 0;
               4'b0010: slot = 1;
               4'b0100: slot = 2;
               4'b1000: slot = 3;
               default: slot = -1;
            endcase
            if (slot < 0) begin
               n_checks++; n_errors++;
               $display("FAIL digit_sel_onehot: got %b expected one-hot", bus_a.o_digit_sel);
            end else begin
               seen_seg[slot] = bus_a.o_seg;
               seen_mask[slot] = 1'b1;
            end
            seen_ovf = bus_a.o_ovf;
            collect_left--;
            if (collect_left == 0) begin
               if (exp_q.size() == 0) begin
                  n_checks++; n_errors++;
                  $display("FAIL unexpected_display: got a display event expected none");
               end else begin
                  logic [16:0] e;
                  e = exp_q.pop_front();
                  chk("digits_seen", 32'(seen_mask), 32'hF);
                  for (int p = 0; p < 4; p++)
                     chk($sformatf("seg_digit%0d_val%0h", p, e[15:0]),
                         32'(seen_seg[p]), 32'(seg_model(e[15:0], p)));
                  chk($sformatf("ovf_val%0h", e[15:0]), 32'(seen_ovf), 32'(e[16]));
               end
            end
         end else if (snap_req) begin
            snap_req     = 1'b0;
            collect_left = 8;
            seen_mask    = '0;
         end
         if (bus_a.o_busy) begin
            busy_run++;
            if (busy_run == 15) begin
               busy_run     = 0;
               n_commits++;
               collect_left = 8;
               seen_mask    = '0;
            end
         end else begin
            if (prev_busy) chk("busy_len_mod15", 32'(busy_run), 32'd0);
            busy_run = 0;
         end
         prev_busy = bus_a.o_busy;
      end
   end

   // ---------------- stimulus ----------------
   task automatic pulse(input logic [13:0] v);
      @(negedge clk);
      bus_a.i_count  = v;
      bus_a.i_update = 1'b1;
      @(negedge clk);
      bus_a.i_update = 1'b0;
   endtask

   task automatic expect_conv(input logic [15:0] bcd, input logic ovf);
      exp_q.push_back({ovf, bcd});
      n_exp_commits++;
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (bus_a.o_busy && k < 200) begin
         @(negedge clk);
         k++;
      end
      if (k >= 200) begin
         n_checks++; n_errors++;
         $display("FAIL busy_timeout: got busy after %0d cycles expected idle", k);
      end
      repeat (12) @(negedge clk);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_a_sel"},  32'(bus_a.o_digit_sel), 32'b0001);
      chk({tag, "_a_seg"},  32'(bus_a.o_seg),       32'h3F);
      chk({tag, "_a_busy"}, 32'(bus_a.o_busy),      32'd0);
      chk({tag, "_a_ovf"},  32'(bus_a.o_ovf),       32'd0);
      chk({tag, "_b_sel"},  32'(bus_b.o_digit_sel), 32'b0001);
      chk({tag, "_b_seg"},  32'(bus_b.o_seg),       32'h3F);
   endtask

   initial begin
      bus_a.i_count = '0; bus_a.i_update = 1'b0;
      bus_b.i_count = '0; bus_b.i_update = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk_reset_vals("por");

      // scan sequence on the SCAN_DIV=4 instance
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      for (int k = 0; k < 32; k++) begin
         int pos;
         pos = (k / 4) % 4;
         chk($sformatf("scan_sel_c%0d", k), 32'(bus_b.o_digit_sel), 32'(1 << pos));
         chk($sformatf("scan_seg_c%0d", k), 32'(bus_b.o_seg), 32'(seg_model(16'h0000, pos)));
         @(negedge clk);
         #1;
      end

      expect_conv(16'h1234, 1'b0); pulse(14'd1234);  wait_done();
      expect_conv(16'h9999, 1'b1); pulse(14'd12000); wait_done();
      expect_conv(16'h0000, 1'b0); pulse(14'd0);     wait_done();
      expect_conv(16'h9999, 1'b0); pulse(14'd9999);  wait_done();
      expect_conv(16'h9999, 1'b1); pulse(14'd10000); wait_done();
      expect_conv(16'h0007, 1'b0); pulse(14'd7);     wait_done();

      // requests during CONV merge into a single follow-up conversion
      expect_conv(16'h0005, 1'b0);
      expect_conv(16'h0043, 1'b0);
      pulse(14'd5);
      repeat (2) @(negedge clk);
      pulse(14'd42);
      pulse(14'd43);
      wait_done();

      // reset in CONV cycle 7 discards the conversion
      pulse(14'd9876);
      repeat (6) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("midconv");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      chk("no_commit_after_reset_busy", 32'(bus_a.o_busy), 32'd0);
      exp_q.push_back({1'b0, 16'h0000});
      snap_req = 1'b1;
      repeat (12) @(negedge clk);

      // first request honoured right after reset release
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bus_a.i_count  = 14'd8;
      bus_a.i_update = 1'b1;
      expect_conv(16'h0008, 1'b0);
      @(negedge clk);
      bus_a.i_update = 1'b0;
      chk("busy_after_release", 32'(bus_a.o_busy), 32'd1);
      wait_done();

      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("commit_count", 32'(n_commits), 32'(n_exp_commits));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
